// File: rtl/tx_frame_sequencer.sv
// tx_frame_sequencer: sequences the PICC->PCD response.
// After the PCD frame ends it times the frame delay, retries on the 128-tick
// grid if upstream data is late, sends the start-of-communication bit and then
// relays upstream bits to the bit encoder until the last bit period completes.
module tx_frame_sequencer #(
    parameter int FDT_N    = 9,
    parameter int FDT_TRIM = 0,
    parameter int MAX_GRID = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_eoc,
    input  logic rx_last_bit,
    input  logic in_data,
    input  logic in_data_valid,
    input  logic in_last_bit,
    output logic in_req,
    output logic enc_en,
    output logic enc_data,
    output logic enc_data_valid,
    output logic enc_last_bit,
    input  logic enc_req,
    input  logic enc_last_tick,
    output logic busy,
    output logic tx_done,
    output logic fdt_missed,
    output logic underrun
);

    // Counter must hold the longest delay, FDT_N*128 + 84.
    localparam int CNT_W  = $clog2(FDT_N * 128 + 84);
    localparam int SLOT_W = (MAX_GRID < 1) ? 1 : $clog2(MAX_GRID + 1);

    // Load values are one less than the delay so that expiry at cnt==0 puts
    // the encoder enable exactly FDT - FDT_TRIM edges after rx_eoc was sampled.
    localparam int LOAD_ONE_I  = FDT_N * 128 + 84 - FDT_TRIM - 1;
    localparam int LOAD_ZERO_I = FDT_N * 128 + 20 - FDT_TRIM - 1;

    localparam logic [CNT_W-1:0]  LOAD_ONE    = CNT_W'(LOAD_ONE_I);
    localparam logic [CNT_W-1:0]  LOAD_ZERO   = CNT_W'(LOAD_ZERO_I);
    localparam logic [CNT_W-1:0]  GRID_RELOAD = CNT_W'(127);
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
    localparam logic [SLOT_W-1:0] SLOT_ONE    = SLOT_W'(1);
    localparam logic [SLOT_W-1:0] SLOT_LAST   = SLOT_W'(MAX_GRID);

    typedef enum logic [2:0] {
        IDLE,
        FDT_WAIT,
        GRID,
        SOC,
        DATA,
        DRAIN
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_n;
    logic [SLOT_W-1:0]   slot;
    logic [SLOT_W-1:0]   slot_n;
    logic                missed_n;
    logic [CNT_W-1:0]    load_val;

    // Delay to load for a new PCD frame end, picked by its last bit.
    assign load_val = rx_last_bit ? LOAD_ONE : LOAD_ZERO;

    // State, timers and the registered missed-slot pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            slot       <= '0;
            fdt_missed <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            slot       <= slot_n;
            fdt_missed <= missed_n;
        end
    end

    // Next-state logic and encoder/upstream handshake outputs.
    always_comb begin
        state_n        = state;
        cnt_n          = cnt;
        slot_n         = slot;
        missed_n       = 1'b0;
        in_req         = 1'b0;
        enc_en         = 1'b0;
        enc_data       = 1'b0;
        enc_data_valid = 1'b0;
        enc_last_bit   = 1'b0;
        tx_done        = 1'b0;
        underrun       = 1'b0;

        case (state)
            IDLE: begin
                if (rx_eoc) begin
                    cnt_n   = load_val;
                    slot_n  = '0;
                    state_n = FDT_WAIT;
                end
            end

            FDT_WAIT: begin
                if (rx_eoc) begin
                    // A newer PCD frame end restarts the delay.
                    cnt_n  = load_val;
                    slot_n = '0;
                end else if (cnt == '0) begin
                    if (in_data_valid) begin
                        state_n = SOC;
                    end else begin
                        cnt_n   = GRID_RELOAD;
                        slot_n  = SLOT_ONE;
                        state_n = GRID;
                    end
                end else begin
                    cnt_n = cnt - CNT_ONE;
                end
            end

            GRID: begin
                if (rx_eoc) begin
                    cnt_n   = load_val;
                    slot_n  = '0;
                    state_n = FDT_WAIT;
                end else if (cnt == '0) begin
                    if (in_data_valid) begin
                        slot_n  = '0;
                        state_n = SOC;
                    end else if (slot == SLOT_LAST) begin
                        // Out of grid slots: give up on this response.
                        missed_n = 1'b1;
                        slot_n   = '0;
                        state_n  = IDLE;
                    end else begin
                        cnt_n  = GRID_RELOAD;
                        slot_n = slot + SLOT_ONE;
                    end
                end else begin
                    cnt_n = cnt - CNT_ONE;
                end
            end

            SOC: begin
                // Start-of-communication bit is a constant 1, never the last.
                enc_en         = 1'b1;
                enc_data       = 1'b1;
                enc_data_valid = 1'b1;
                if (enc_req) begin
                    state_n = DATA;
                end
            end

            DATA: begin
                enc_en         = 1'b1;
                enc_data       = in_data;
                enc_data_valid = in_data_valid;
                enc_last_bit   = in_last_bit;
                in_req         = enc_req;
                if (enc_req) begin
                    if (!in_data_valid) begin
                        // Upstream starved: let the current period finish.
                        underrun = 1'b1;
                        state_n  = DRAIN;
                    end else if (in_last_bit) begin
                        state_n = DRAIN;
                    end
                end
            end

            DRAIN: begin
                // Hold the encoder on until its final bit period ends.
                enc_en = 1'b1;
                if (enc_last_tick) begin
                    tx_done = 1'b1;
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Directed testbench for tx_frame_sequencer with a behavioural bit encoder
// (128-tick periods, req at tick 63, last tick at 127) and a bit-level source.
module tb_tx_frame_sequencer;

    logic clk = 1'b0;
    logic rst;
    logic rx_eoc;
    logic rx_last_bit;
    logic in_data;
    logic in_data_valid;
    logic in_last_bit;
    logic in_req;
    logic enc_en;
    logic enc_data;
    logic enc_data_valid;
    logic enc_last_bit;
    logic enc_req;
    logic enc_last_tick;
    logic busy;
    logic tx_done;
    logic fdt_missed;
    logic underrun;

    // Outputs of the FDT_TRIM=10 instance.
    logic t_in_req, t_enc_en, t_enc_data, t_enc_data_valid, t_enc_last_bit;
    logic t_busy, t_tx_done, t_fdt_missed, t_underrun;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    tx_frame_sequencer #(.FDT_N(9), .FDT_TRIM(0), .MAX_GRID(4)) dut (
        .clk(clk), .rst(rst), .rx_eoc(rx_eoc), .rx_last_bit(rx_last_bit),
        .in_data(in_data), .in_data_valid(in_data_valid), .in_last_bit(in_last_bit),
        .in_req(in_req), .enc_en(enc_en), .enc_data(enc_data),
        .enc_data_valid(enc_data_valid), .enc_last_bit(enc_last_bit),
        .enc_req(enc_req), .enc_last_tick(enc_last_tick), .busy(busy),
        .tx_done(tx_done), .fdt_missed(fdt_missed), .underrun(underrun)
    );

    tx_frame_sequencer #(.FDT_N(9), .FDT_TRIM(10), .MAX_GRID(4)) dut_trim (
        .clk(clk), .rst(rst), .rx_eoc(rx_eoc), .rx_last_bit(rx_last_bit),
        .in_data(in_data), .in_data_valid(in_data_valid), .in_last_bit(in_last_bit),
        .in_req(t_in_req), .enc_en(t_enc_en), .enc_data(t_enc_data),
        .enc_data_valid(t_enc_data_valid), .enc_last_bit(t_enc_last_bit),
        .enc_req(enc_req), .enc_last_tick(enc_last_tick), .busy(t_busy),
        .tx_done(t_tx_done), .fdt_missed(t_fdt_missed), .underrun(t_underrun)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Encoder model: tick counter runs while enabled.
    logic [6:0] tc = 7'd0;
    always @(posedge clk) begin
        if (!enc_en) tc <= 7'd0;
        else         tc <= tc + 7'd1;
    end
    assign enc_req       = enc_en && (tc == 7'd63);
    assign enc_last_tick = enc_en && (tc == 7'd127);

    // Upstream source model.
    logic [7:0] pattern = 8'h00;
    int idx = 0;
    logic up_clr = 1'b0;
    logic up_en = 1'b0;
    int valid_limit = 8;
    always @(posedge clk) begin
        if (up_clr)      idx <= 0;
        else if (in_req) idx <= idx + 1;
    end
    assign in_data       = (idx < 8) ? pattern[idx[2:0]] : 1'b0;
    assign in_last_bit   = (idx == 7);
    assign in_data_valid = up_en && (idx < valid_limit);

    // Monitor, sampled on the falling edge.
    logic mon_clr = 1'b0;
    logic prev_en = 1'b0, prev_ten = 1'b0;
    logic rise_seen, fall_seen, trim_rise_seen, soc_seen;
    int rise_cyc, fall_cyc, trim_rise_cyc, ticks_at_fall, lt_cnt;
    int nreq, done_cnt, done_cyc, ur_cnt, ur_cyc, miss_cnt, miss_cyc;
    int req_cyc [8];
    logic req_dat [8];
    logic req_last [8];
    logic soc_dat, soc_vld, soc_inreq;

    always @(negedge clk) begin
        if (mon_clr) begin
            rise_seen = 0; fall_seen = 0; trim_rise_seen = 0; soc_seen = 0;
            rise_cyc = -1; fall_cyc = -1; trim_rise_cyc = -1; ticks_at_fall = 0;
            lt_cnt = 0; nreq = 0; done_cnt = 0; done_cyc = -1;
            ur_cnt = 0; ur_cyc = -1; miss_cnt = 0; miss_cyc = -1;
            soc_dat = 0; soc_vld = 0; soc_inreq = 0;
        end else begin
            if (enc_en && !prev_en && !rise_seen) begin rise_seen = 1; rise_cyc = cyc; end
            if (!enc_en && prev_en && !fall_seen) begin
                fall_seen = 1; fall_cyc = cyc; ticks_at_fall = lt_cnt;
            end
            if (t_enc_en && !prev_ten && !trim_rise_seen) begin
                trim_rise_seen = 1; trim_rise_cyc = cyc;
            end
            if (enc_last_tick) lt_cnt++;
            if (enc_req && !soc_seen) begin
                soc_seen = 1; soc_dat = enc_data; soc_vld = enc_data_valid; soc_inreq = in_req;
            end
            if (in_req) begin
                if (nreq < 8) begin
                    req_cyc[nreq] = cyc; req_dat[nreq] = enc_data; req_last[nreq] = enc_last_bit;
                end
                nreq++;
            end
            if (tx_done) begin done_cnt++; done_cyc = cyc; end
            if (underrun) begin ur_cnt++; ur_cyc = cyc; end
            if (fdt_missed) begin miss_cnt++; miss_cyc = cyc; end
        end
        prev_en  = enc_en;
        prev_ten = t_enc_en;
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; rx_eoc = 1'b0; rx_last_bit = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic prep(input logic [7:0] pat, input logic en, input int lim);
        apply_reset();
        pattern = pat; up_en = en; valid_limit = lim;
        @(posedge clk); #1;
        mon_clr = 1'b1; up_clr = 1'b1;
        @(posedge clk); #1;
        mon_clr = 1'b0; up_clr = 1'b0;
    endtask

    task automatic send_eoc(input logic lb, output int t0);
        @(negedge clk);
        rx_eoc = 1'b1; rx_last_bit = lb;
        @(posedge clk); #1;
        t0 = cyc;
        rx_eoc = 1'b0; rx_last_bit = 1'b0;
    endtask

    task automatic wait_rise(input int budget);
        for (int i = 0; i < budget && !rise_seen; i++) @(negedge clk);
        #1;
        checks++;
        if (!rise_seen) begin
            failures++;
            $display("FAIL rise_timeout: enc_en never rose within %0d cycles", budget);
        end
    endtask

    task automatic wait_fall(input int budget);
        for (int i = 0; i < budget && !fall_seen; i++) @(negedge clk);
        #1;
        checks++;
        if (!fall_seen) begin
            failures++;
            $display("FAIL fall_timeout: enc_en never fell within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({enc_en, enc_data, enc_data_valid, enc_last_bit, in_req, busy, tx_done,
             fdt_missed, underrun} !== 9'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b want 0", {enc_en, enc_data, enc_data_valid,
                     enc_last_bit, in_req, busy, tx_done, fdt_missed, underrun});
        end
        checks++;
        if ({t_enc_en, t_enc_data, t_enc_data_valid, t_enc_last_bit, t_in_req, t_busy,
             t_tx_done, t_fdt_missed, t_underrun} !== 9'b0) begin
            failures++;
            $display("FAIL reset_outputs_trim: got %b want 0", {t_enc_en, t_enc_data,
                     t_enc_data_valid, t_enc_last_bit, t_in_req, t_busy, t_tx_done,
                     t_fdt_missed, t_underrun});
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_full_frame();
        int t0;
        prep(8'b1011_0010, 1'b1, 8);
        send_eoc(1'b1, t0);
        wait_rise(1500);
        checks++;
        if (rise_cyc - t0 !== 1236) begin
            failures++; $display("FAIL fdt_one: delay %0d want 1236", rise_cyc - t0);
        end
        checks++;
        if (trim_rise_cyc - t0 !== 1226) begin
            failures++; $display("FAIL fdt_one_trim: delay %0d want 1226", trim_rise_cyc - t0);
        end
        wait_fall(1400);
        checks++;
        if ({soc_dat, soc_vld, soc_inreq} !== 3'b110) begin
            failures++; $display("FAIL soc_bit: data/valid/in_req %b want 110", {soc_dat, soc_vld, soc_inreq});
        end
        checks++;
        if (nreq !== 8) begin
            failures++; $display("FAIL req_count: got %0d want 8", nreq);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (req_cyc[k] - rise_cyc !== 191 + 128 * k) begin
                failures++;
                $display("FAIL req_time[%0d]: offset %0d want %0d", k, req_cyc[k] - rise_cyc, 191 + 128 * k);
            end
            checks++;
            if (req_dat[k] !== pattern[k] || req_last[k] !== (k == 7)) begin
                failures++;
                $display("FAIL req_bit[%0d]: data %b last %b want %b %b", k, req_dat[k], req_last[k],
                         pattern[k], (k == 7));
            end
        end
        checks++;
        if (done_cnt !== 1 || done_cyc - rise_cyc !== 1151) begin
            failures++; $display("FAIL tx_done: count %0d offset %0d want 1 1151", done_cnt, done_cyc - rise_cyc);
        end
        checks++;
        if (fall_cyc - rise_cyc !== 1152 || ticks_at_fall !== 9) begin
            failures++;
            $display("FAIL frame_len: cycles %0d ticks %0d want 1152 9", fall_cyc - rise_cyc, ticks_at_fall);
        end
        checks++;
        if (ur_cnt !== 0 || busy !== 1'b0) begin
            failures++; $display("FAIL frame_end_state: underrun %0d busy %b want 0 0", ur_cnt, busy);
        end
    endtask

    task automatic test_fdt_zero();
        int t0;
        prep(8'b0101_1100, 1'b1, 8);
        send_eoc(1'b0, t0);
        wait_rise(1500);
        checks++;
        if (rise_cyc - t0 !== 1172) begin
            failures++; $display("FAIL fdt_zero: delay %0d want 1172", rise_cyc - t0);
        end
        checks++;
        if (trim_rise_cyc - t0 !== 1162) begin
            failures++; $display("FAIL fdt_zero_trim: delay %0d want 1162", trim_rise_cyc - t0);
        end
        wait_fall(1400);
    endtask

    task automatic test_grid_slot();
        int t0;
        prep(8'b1111_0000, 1'b0, 8);
        send_eoc(1'b1, t0);
        for (int i = 0; i < 2000 && cyc < t0 + 1436; i++) @(negedge clk);
        up_en = 1'b1;
        wait_rise(400);
        checks++;
        if (rise_cyc - t0 !== 1236 + 256) begin
            failures++; $display("FAIL grid_slot2: delay %0d want %0d", rise_cyc - t0, 1236 + 256);
        end
        wait_fall(1400);
        checks++;
        if (done_cnt !== 1 || nreq !== 8) begin
            failures++; $display("FAIL grid_frame: done %0d req %0d want 1 8", done_cnt, nreq);
        end
    endtask

    task automatic test_fdt_missed();
        int t0;
        prep(8'h00, 1'b0, 8);
        send_eoc(1'b1, t0);
        for (int i = 0; i < 2500 && miss_cnt == 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (miss_cnt !== 1 || miss_cyc - t0 !== 1236 + 512) begin
            failures++; $display("FAIL fdt_missed: count %0d delay %0d want 1 %0d", miss_cnt, miss_cyc - t0, 1236 + 512);
        end
        checks++;
        if (rise_seen !== 1'b0 || nreq !== 0 || busy !== 1'b0) begin
            failures++; $display("FAIL missed_quiet: rise %b req %0d busy %b want 0 0 0", rise_seen, nreq, busy);
        end
    endtask

    task automatic test_underrun();
        int t0;
        prep(8'b1100_1010, 1'b1, 2);
        send_eoc(1'b1, t0);
        wait_rise(1500);
        wait_fall(1400);
        checks++;
        if (ur_cnt !== 1 || ur_cyc - rise_cyc !== 447) begin
            failures++; $display("FAIL underrun: count %0d offset %0d want 1 447", ur_cnt, ur_cyc - rise_cyc);
        end
        checks++;
        if (fall_cyc - rise_cyc !== 512 || done_cnt !== 1) begin
            failures++; $display("FAIL underrun_drain: len %0d done %0d want 512 1", fall_cyc - rise_cyc, done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        prep(8'b1010_1010, 1'b1, 8);
        send_eoc(1'b1, t0);
        wait_rise(1500);
        for (int i = 0; i < 600 && nreq < 2; i++) @(negedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({enc_en, in_req, busy} !== 3'b000) begin
            failures++; $display("FAIL reset_mid: en/in_req/busy %b want 000", {enc_en, in_req, busy});
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        #1;
        checks++;
        if (done_cnt !== 0 || enc_en !== 1'b0) begin
            failures++; $display("FAIL reset_mid_quiet: done %0d en %b want 0 0", done_cnt, enc_en);
        end
    endtask

    task automatic test_restart();
        int t0;
        int t1;
        prep(8'b0011_0011, 1'b1, 8);
        send_eoc(1'b1, t0);
        repeat (500) @(negedge clk);
        send_eoc(1'b0, t1);
        wait_rise(1500);
        checks++;
        if (rise_cyc - t1 !== 1172) begin
            failures++; $display("FAIL restart: delay %0d want 1172", rise_cyc - t1);
        end
        wait_fall(1400);
    endtask

    initial begin
        rst = 1'b1; rx_eoc = 1'b0; rx_last_bit = 1'b0;
        mon_clr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mon_clr = 1'b0;
        test_reset();
        test_full_frame();
        test_fdt_zero();
        test_grid_slot();
        test_fdt_missed();
        test_underrun();
        test_reset_mid();
        test_restart();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tx_frame_sequencer.md
Name: tx_frame_sequencer

Overview:
Sequences the PICC->PCD response path. After the PCD frame ends, it times the ISO/IEC 14443-3 frame delay time (FDT) and enables bit_encoder on the correct 128-tick grid. It inserts the start-of-communication bit (logic 1), then relays data bits from the upstream bit-level tx_interface source. It disables the encoder after the last bit period completes.

Parameters:
FDT_N, 9, n in FDT = n*128 + (84 if last PCD bit was 1, else 20) ticks
FDT_TRIM, 0, ticks subtracted from the FDT load value to compensate for downstream analogue/encoder latency; range 0..19
MAX_GRID, 4, extra 128-tick grid slots tried when upstream data is not ready at FDT expiry

Ports:
clk  in  1  carrier-derived clock, one tick per cycle
rst  in  1  asynchronous, active-high reset
rx_eoc  in  1  one-cycle pulse: PCD frame ended
rx_last_bit  in  1  value of the PCD frame's last bit, valid with rx_eoc
in_data  in  1  upstream bit to send
in_data_valid  in  1  upstream has a bit presented
in_last_bit  in  1  presented bit is the frame's last
in_req  out  1  one-cycle pulse: presented bit consumed, present the next bit from the next cycle
enc_en  out  1  bit_encoder enable
enc_data  out  1  bit to bit_encoder
enc_data_valid  out  1  to bit_encoder
enc_last_bit  out  1  to bit_encoder
enc_req  in  1  bit_encoder req: current bit consumed (mid-bit)
enc_last_tick  in  1  bit_encoder last tick of a bit period
busy  out  1  state != IDLE
tx_done  out  1  one-cycle pulse: frame fully transmitted
fdt_missed  out  1  one-cycle pulse: no data within MAX_GRID slots
underrun  out  1  one-cycle pulse: in_data_valid low at enc_req in DATA

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0. rst mid-frame drops enc_en in the same cycle (async), with no tx_done.
- State IDLE: on rx_eoc, load cnt = FDT_N*128 + (rx_last_bit ? 84 : 20) - FDT_TRIM - 1, then go to FDT_WAIT.
- State FDT_WAIT: decrement cnt each cycle. When cnt==0:
  - if in_data_valid, go to SOC; enc_en is high from the next edge. enc_en is first high exactly FDT-FDT_TRIM cycles after the edge that sampled rx_eoc.
  - otherwise, go to GRID with cnt=127 and slot=1.
- State GRID: decrement cnt. When cnt==0:
  - if in_data_valid, go to SOC;
  - else if slot==MAX_GRID, pulse fdt_missed and go to IDLE;
  - else reload cnt=127 and increment slot.
- rx_eoc during FDT_WAIT or GRID restarts the IDLE load sequence with the new rx_last_bit. rx_eoc is ignored in SOC, DATA and DRAIN.
- State SOC:
  - enc_en=1, enc_data=1, enc_data_valid=1, enc_last_bit=0; in_req=0.
  - On enc_req, go to DATA.
- State DATA:
  - enc_data/enc_data_valid/enc_last_bit are combinational copies of the in_* signals; in_req = enc_req.
  - On enc_req with in_data_valid && in_last_bit, go to DRAIN.
  - On enc_req with !in_data_valid, pulse underrun and go to DRAIN. The encoder still finishes the current period.
- State DRAIN:
  - enc_data_valid=0, in_req=0.
  - On the first enc_last_tick: enc_en goes low at the next edge, tx_done pulses in that same cycle, go to IDLE.
- Upstream must hold in_* stable from bit-period start until in_req.
- in_req never pulses outside DATA.
- Frame length in encoder bit periods = 1 + number of data bits consumed.
- Counter width: ceil(log2(FDT_N*128+84)) bits, sized from parameters.

Test Plan:
- FDT_N=9, FDT_TRIM=0, data ready; rx_eoc with rx_last_bit=1 at edge T -> enc_en first high at T+1236; SOC bit 1 sent; no in_req before the first data enc_req.
- Same with rx_last_bit=0 -> enc_en first high at T+1172. With FDT_TRIM=10 -> T+1162.
- in_data_valid asserted 200 cycles after FDT expiry -> enc_en rises at expiry+256 (slot 2). Data never valid, MAX_GRID=4 -> fdt_missed pulses at expiry+512, enc_en stays 0.
- 8 random data bits, last flagged -> exactly 8 in_req pulses, spaced 128 cycles apart; 9 encoder periods total; enc_en falls the cycle after the 9th enc_last_tick; tx_done is a single pulse.
- in_data_valid dropped before the 3rd data bit -> underrun pulse at that enc_req, then DRAIN, enc_en falls after the next enc_last_tick.
- Reset asserted mid-DATA -> enc_en, in_req, busy all 0 immediately; second rx_eoc during FDT_WAIT -> timing restarts from the second pulse.
